// File: rtl/fp_pkg.sv
// Shared FPU definitions: rounding modes, flag positions, special-value builders.
package fp_pkg;

   localparam int STAGES = 6;
   localparam int PACK_W = 128;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} specialT;

   // Results are right-aligned in PACK_W bits; callers cast down to their width.
   function automatic logic [PACK_W-1:0] canonicalNan(input int expW, input int fracW);
      logic [PACK_W-1:0] r;
      r = ((PACK_W'(1) << expW) - PACK_W'(1)) << (fracW - 1);
      r = r | (PACK_W'(1) << (fracW - 2));
      return r;
   endfunction

   // {exp, mantissa} of the largest finite magnitude, sign excluded.
   function automatic logic [PACK_W-1:0] maxFinite(input int expW, input int fracW);
      logic [PACK_W-1:0] r;
      r = ((PACK_W'(1) << expW) - PACK_W'(2)) << (fracW - 1);
      r = r | ((PACK_W'(1) << (fracW - 1)) - PACK_W'(1));
      return r;
   endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational rounder: applies the rounding mode to a normalised significand
// with guard/round/sticky and resolves mantissa carry and overflow.
module fp_round
   import fp_pkg::*;
#(
   parameter int FRAC_WIDTH = 24,
   parameter int EXP_WIDTH  = 8
) (
   input  logic                              sign,
   input  logic [FRAC_WIDTH-1:0]             mant,
   input  logic [2:0]                        grs,
   input  logic signed [EXP_WIDTH+2:0]       expVal,
   input  logic [2:0]                        rm,
   input  logic                              tiny,
   output logic [EXP_WIDTH+FRAC_WIDTH-2:0]   result,
   output logic                              of,
   output logic                              uf,
   output logic                              nx
);

   localparam int XW = EXP_WIDTH + 3;
   localparam int BW = EXP_WIDTH + FRAC_WIDTH - 1;
   localparam logic signed [XW-1:0] MAX_EXP = XW'((1 << EXP_WIDTH) - 1);
   localparam logic [BW-1:0] MAXF = BW'(maxFinite(EXP_WIDTH, FRAC_WIDTH));

   logic                  inexact, inc, toInf, ovf;
   logic [FRAC_WIDTH:0]   sum;
   logic [FRAC_WIDTH-1:0] mantR;
   logic signed [XW-1:0]  expR;

   assign inexact = |grs;

   always_comb begin
      inc   = 1'b0;
      toInf = 1'b1;
      case (rm)
         RM_RTZ: begin inc = 1'b0;             toInf = 1'b0;  end
         RM_RDN: begin inc = sign & inexact;   toInf = sign;  end
         RM_RUP: begin inc = ~sign & inexact;  toInf = ~sign; end
         RM_RMM: begin inc = grs[2];           toInf = 1'b1;  end
         default: begin inc = grs[2] & (grs[1] | grs[0] | mant[0]); toInf = 1'b1; end
      endcase
   end

   // A carry out of the top bit renormalises by one; a subnormal that rounds up
   // into the hidden bit becomes normal through the hidden-bit test below.
   assign sum   = {1'b0, mant} + {{FRAC_WIDTH{1'b0}}, inc};
   assign mantR = sum[FRAC_WIDTH] ? sum[FRAC_WIDTH:1] : sum[FRAC_WIDTH-1:0];
   assign expR  = expVal + {{(XW-1){1'b0}}, sum[FRAC_WIDTH]};
   assign ovf   = mantR[FRAC_WIDTH-1] && (expR >= MAX_EXP);

   always_comb begin
      result = {(mantR[FRAC_WIDTH-1] ? expR[EXP_WIDTH-1:0] : {EXP_WIDTH{1'b0}}),
                mantR[FRAC_WIDTH-2:0]};
      of = 1'b0;
      uf = tiny & inexact;
      nx = inexact;
      if (ovf) begin
         result = toInf ? {{EXP_WIDTH{1'b1}}, {(FRAC_WIDTH-1){1'b0}}} : MAXF;
         of = 1'b1;
         uf = 1'b0;
         nx = 1'b1;
      end
   end

endmodule

// File: rtl/floating_point_multiply_ieee.sv
// Six-stage IEEE-754 multiplier: unpack, multiply, normalise, denormalise,
// extract GRS, round/select. One common enable stalls the whole pipe.
module floating_point_multiply_ieee
   import fp_pkg::*;
#(
   parameter int FRAC_WIDTH = 24,
   parameter int EXP_WIDTH  = 8,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                            clkIn,
   input  logic                            rstNIn,
   input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataAIn,
   input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataBIn,
   input  logic [2:0]                      rmIn,
   input  logic [TAG_WIDTH-1:0]            tagIn,
   input  logic                            validIn,
   output logic                            readyOut,
   output logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataOut,
   output logic [4:0]                      flagsOut,
   output logic [TAG_WIDTH-1:0]            tagOut,
   output logic                            validOut,
   input  logic                            readyIn
);

   localparam int W    = FRAC_WIDTH + EXP_WIDTH;
   localparam int MW   = FRAC_WIDTH - 1;
   localparam int XW   = EXP_WIDTH + 3;
   localparam int PW   = 2 * FRAC_WIDTH;
   localparam int LZW  = $clog2(PW + 1);
   localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
   localparam logic [W-1:0] QNAN = W'(canonicalNan(EXP_WIDTH, FRAC_WIDTH));

   typedef struct packed {logic zero; logic inf; logic nan; logic snan;} clsT;

   typedef struct packed {
      logic                 sign;
      logic [2:0]           rm;
      logic [TAG_WIDTH-1:0] tag;
      specialT              spec;
      logic                 nv;
   } ctlT;

   typedef struct packed {
      ctlT ctl; logic [FRAC_WIDTH-1:0] sigA; logic [FRAC_WIDTH-1:0] sigB; logic [XW-1:0] expo;
   } s1T;
   typedef struct packed {ctlT ctl; logic [PW-1:0] prod; logic [XW-1:0] expo;} s2T;
   typedef struct packed {
      ctlT ctl; logic [PW-1:0] prod; logic sticky; logic [XW-1:0] expo; logic tiny;
   } s4T;
   typedef struct packed {
      ctlT ctl; logic [FRAC_WIDTH-1:0] mant; logic [2:0] grs; logic [XW-1:0] expo; logic tiny;
   } s5T;

   function automatic clsT classify(input logic [W-1:0] d);
      clsT r;
      logic [EXP_WIDTH-1:0] e;
      logic [MW-1:0] m;
      e      = d[W-2 -: EXP_WIDTH];
      m      = d[MW-1:0];
      r.zero = (e == '0) && (m == '0);
      r.inf  = (e == '1) && (m == '0);
      r.nan  = (e == '1) && (m != '0);
      r.snan = r.nan && !m[MW-1];
      return r;
   endfunction

   logic [STAGES:1] vldPipe;
   logic            stall, en, accept;
   s1T s1d, s1q;
   s2T s2d, s2q, s3d, s3q;
   s4T s4d, s4q;
   s5T s5d, s5q;
   clsT ca, cb;
   logic [EXP_WIDTH-1:0] expA, expB;
   logic [LZW-1:0]       lz;
   logic                 found;
   logic [XW-1:0]        shAmt;
   logic [2*PW-1:0]      ext;
   logic [W-2:0]         rndRes;
   logic                 rndOf, rndUf, rndNx;
   logic [W-1:0]         dataD;
   logic [4:0]           flagsD;

   assign validOut = vldPipe[STAGES];
   assign stall    = vldPipe[STAGES] & ~readyIn;
   assign readyOut = ~stall;
   assign en       = ~stall;
   assign accept   = validIn & readyOut;

   // Stage 1: classify operands; subnormals use exponent 1 with a clear hidden bit.
   always_comb begin
      s1d  = '0;
      ca   = classify(dataAIn);
      cb   = classify(dataBIn);
      expA = dataAIn[W-2 -: EXP_WIDTH];
      expB = dataBIn[W-2 -: EXP_WIDTH];
      s1d.ctl.sign = dataAIn[W-1] ^ dataBIn[W-1];
      s1d.ctl.rm   = rmIn;
      s1d.ctl.tag  = tagIn;
      s1d.ctl.nv   = ca.snan | cb.snan | (ca.inf & cb.zero) | (ca.zero & cb.inf);
      if (ca.nan | cb.nan | (ca.inf & cb.zero) | (ca.zero & cb.inf)) s1d.ctl.spec = SP_NAN;
      else if (ca.inf | cb.inf)                                      s1d.ctl.spec = SP_INF;
      else if (ca.zero | cb.zero)                                    s1d.ctl.spec = SP_ZERO;
      else                                                           s1d.ctl.spec = SP_NONE;
      s1d.sigA = {|expA, dataAIn[MW-1:0]};
      s1d.sigB = {|expB, dataBIn[MW-1:0]};
      s1d.expo = {3'b000, expA | EXP_WIDTH'(expA == '0)}
               + {3'b000, expB | EXP_WIDTH'(expB == '0)} - XW'(BIAS);
   end

   always_comb begin
      s2d      = '0;
      s2d.ctl  = s1q.ctl;
      s2d.prod = PW'(s1q.sigA) * PW'(s1q.sigB);
      s2d.expo = s1q.expo;
   end

   // Stage 3: bring the leading one to the top; the product's binary point
   // sits at PW-2, hence the +1 on the exponent.
   always_comb begin
      lz    = '0;
      found = 1'b0;
      for (int i = PW - 1; i >= 0; i--) begin
         if (!found) begin
            if (s2q.prod[i]) found = 1'b1;
            else             lz    = lz + LZW'(1);
         end
      end
      s3d      = '0;
      s3d.ctl  = s2q.ctl;
      s3d.prod = s2q.prod << lz;
      s3d.expo = s2q.expo + XW'(1) - XW'(lz);
   end

   // Stage 4: results below the normal range shift right to exponent 1,
   // folding the shifted-out bits into sticky.
   always_comb begin
      s4d        = '0;
      s4d.ctl    = s3q.ctl;
      s4d.prod   = s3q.prod;
      s4d.expo   = s3q.expo;
      shAmt      = '0;
      ext        = '0;
      if (s3q.expo[XW-1] || s3q.expo == '0) begin
         shAmt = XW'(1) - s3q.expo;
         if (shAmt > XW'(PW)) shAmt = XW'(PW);
         ext        = {s3q.prod, {PW{1'b0}}} >> shAmt;
         s4d.prod   = ext[2*PW-1:PW];
         s4d.sticky = |ext[PW-1:0];
         s4d.expo   = XW'(1);
         s4d.tiny   = 1'b1;
      end
   end

   always_comb begin
      s5d      = '0;
      s5d.ctl  = s4q.ctl;
      s5d.mant = s4q.prod[PW-1:FRAC_WIDTH];
      s5d.grs  = {s4q.prod[FRAC_WIDTH-1], s4q.prod[FRAC_WIDTH-2],
                  (|s4q.prod[FRAC_WIDTH-3:0]) | s4q.sticky};
      s5d.expo = s4q.expo;
      s5d.tiny = s4q.tiny;
   end

   fp_round #(.FRAC_WIDTH(FRAC_WIDTH), .EXP_WIDTH(EXP_WIDTH)) uRound (
      .sign(s5q.ctl.sign), .mant(s5q.mant), .grs(s5q.grs), .expVal(s5q.expo),
      .rm(s5q.ctl.rm), .tiny(s5q.tiny), .result(rndRes),
      .of(rndOf), .uf(rndUf), .nx(rndNx)
   );

   always_comb begin
      dataD  = {s5q.ctl.sign, rndRes};
      flagsD = '0;
      case (s5q.ctl.spec)
         SP_NAN: begin
            dataD           = QNAN;
            flagsD[FLAG_NV] = s5q.ctl.nv;
         end
         SP_INF:  dataD = {s5q.ctl.sign, {EXP_WIDTH{1'b1}}, {MW{1'b0}}};
         SP_ZERO: dataD = {s5q.ctl.sign, {(W-1){1'b0}}};
         default: begin
            flagsD[FLAG_OF] = rndOf;
            flagsD[FLAG_UF] = rndUf;
            flagsD[FLAG_NX] = rndNx;
         end
      endcase
   end

   always_ff @(posedge clkIn or negedge rstNIn) begin
      if (!rstNIn) begin
         vldPipe  <= '0;
         s1q      <= '0;
         s2q      <= '0;
         s3q      <= '0;
         s4q      <= '0;
         s5q      <= '0;
         dataOut  <= '0;
         flagsOut <= '0;
         tagOut   <= '0;
      end else if (en) begin
         vldPipe  <= {vldPipe[STAGES-1:1], accept};
         s1q      <= s1d;
         s2q      <= s2d;
         s3q      <= s3d;
         s4q      <= s4d;
         s5q      <= s5d;
         dataOut  <= dataD;
         flagsOut <= flagsD;
         tagOut   <= s5q.ctl.tag;
      end
   end

endmodule

// File: tb/tb_floating_point_multiply_ieee.sv
// Directed bench for the pipelined IEEE multiplier: arithmetic vectors,
// stall behaviour, reset flush and a randomly back-pressured stream.
module tb_floating_point_multiply_ieee;

   logic        clkIn = 1'b0;
   logic        rstNIn = 1'b0;
   logic [31:0] dataAIn = '0, dataBIn = '0;
   logic [2:0]  rmIn = '0;
   logic [4:0]  tagIn = '0;
   logic        validIn = 1'b0;
   logic        readyOut;
   logic [31:0] dataOut;
   logic [4:0]  flagsOut;
   logic [4:0]  tagOut;
   logic        validOut;
   logic        readyIn = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clkIn = ~clkIn;

   floating_point_multiply_ieee dut (
      .clkIn(clkIn), .rstNIn(rstNIn), .dataAIn(dataAIn), .dataBIn(dataBIn),
      .rmIn(rmIn), .tagIn(tagIn), .validIn(validIn), .readyOut(readyOut),
      .dataOut(dataOut), .flagsOut(flagsOut), .tagOut(tagOut),
      .validOut(validOut), .readyIn(readyIn)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm, input logic [4:0] tag,
                        input logic [31:0] expData, input logic [4:0] expFlags);
      int cyc;
      @(negedge clkIn);
      dataAIn = a; dataBIn = b; rmIn = rm; tagIn = tag; validIn = 1'b1;
      cyc = 0;
      do begin
         @(negedge clkIn);
         validIn = 1'b0;
         cyc++;
      end while (!validOut && cyc < 20);
      chk({name, " latency"}, cyc, 6);
      chk({name, " data"}, dataOut, expData);
      chk({name, " flags"}, 32'(flagsOut), 32'(expFlags));
      chk({name, " tag"}, 32'(tagOut), 32'(tag));
   endtask

   logic [36:0] q[$];
   logic [36:0] e;
   logic [31:0] a, b, prevData;
   logic [4:0]  prevTag;
   logic        prevStall;
   int          issued, got;

   initial begin
      repeat (3) @(negedge clkIn);
      chk("reset validOut", 32'(validOut), 0);
      chk("reset readyOut", 32'(readyOut), 1);
      chk("reset dataOut", dataOut, 0);
      chk("reset flagsOut", 32'(flagsOut), 0);
      chk("reset tagOut", 32'(tagOut), 0);
      rstNIn = 1'b1;

      runOp("basic",     32'h3FC00000, 32'h40000000, 3'd0, 5'd1,  32'h40400000, 5'b00000);
      runOp("rne",       32'h3F800001, 32'h3F800001, 3'd0, 5'd2,  32'h3F800002, 5'b00001);
      runOp("rtz",       32'h3F800001, 32'h3F800001, 3'd1, 5'd3,  32'h3F800002, 5'b00001);
      runOp("rup",       32'h3F800001, 32'h3F800001, 3'd3, 5'd4,  32'h3F800003, 5'b00001);
      runOp("rdn neg",   32'hBF800001, 32'h3F800001, 3'd2, 5'd5,  32'hBF800003, 5'b00001);
      runOp("rm7 rne",   32'h3F800001, 32'h3F800001, 3'd7, 5'd6,  32'h3F800002, 5'b00001);
      runOp("ovf rne",   32'h7F7FFFFF, 32'h40000000, 3'd0, 5'd7,  32'h7F800000, 5'b00101);
      runOp("ovf rtz",   32'h7F7FFFFF, 32'h40000000, 3'd1, 5'd8,  32'h7F7FFFFF, 5'b00101);
      runOp("ovf rdn",   32'h7F7FFFFF, 32'hC0000000, 3'd2, 5'd9,  32'hFF800000, 5'b00101);
      runOp("ovf rup",   32'h7F7FFFFF, 32'hC0000000, 3'd3, 5'd10, 32'hFF7FFFFF, 5'b00101);
      runOp("inf x 0",   32'h7F800000, 32'h00000000, 3'd0, 5'd11, 32'h7FC00000, 5'b10000);
      runOp("snan",      32'h7F800001, 32'h3F800000, 3'd0, 5'd12, 32'h7FC00000, 5'b10000);
      runOp("qnan",      32'hFFC00000, 32'h3F800000, 3'd0, 5'd13, 32'h7FC00000, 5'b00000);
      runOp("inf x fin", 32'hFF800000, 32'h40000000, 3'd0, 5'd14, 32'hFF800000, 5'b00000);
      runOp("neg zero",  32'h80000000, 32'h3F800000, 3'd0, 5'd15, 32'h80000000, 5'b00000);
      runOp("sub exact", 32'h00800000, 32'h3F000000, 3'd0, 5'd16, 32'h00400000, 5'b00000);
      runOp("tiny rne",  32'h00000001, 32'h3F000000, 3'd0, 5'd17, 32'h00000000, 5'b00011);
      runOp("tiny rup",  32'h00000001, 32'h3F000000, 3'd3, 5'd18, 32'h00000001, 5'b00011);
      runOp("tiny rmm",  32'h00000001, 32'h3F000000, 3'd4, 5'd19, 32'h00000001, 5'b00011);
      runOp("sub->norm", 32'h00FFFFFF, 32'h3F000000, 3'd0, 5'd20, 32'h00800000, 5'b00011);

      // readyIn low on an empty pipe must not stall; a stalled result holds.
      @(negedge clkIn);
      readyIn = 1'b0;
      #1 chk("empty no stall", 32'(readyOut), 1);
      @(negedge clkIn);
      dataAIn = 32'h3FC00000; dataBIn = 32'h40000000; rmIn = 3'd0; tagIn = 5'd21; validIn = 1'b1;
      @(negedge clkIn);
      validIn = 1'b0;
      repeat (8) @(negedge clkIn);
      chk("stall validOut", 32'(validOut), 1);
      chk("stall readyOut", 32'(readyOut), 0);
      chk("stall data", dataOut, 32'h40400000);
      chk("stall tag", 32'(tagOut), 21);
      readyIn = 1'b1;
      @(negedge clkIn);
      chk("stall released", 32'(validOut), 0);

      // Fill with operations that the reset must discard.
      readyIn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dataAIn = 32'h3F800000; dataBIn = 32'h40000000; tagIn = 5'(24 + i); validIn = 1'b1;
         @(negedge clkIn);
      end
      validIn = 1'b0;
      repeat (2) @(negedge clkIn);
      #2 rstNIn = 1'b0;
      #1 chk("mid reset validOut", 32'(validOut), 0);
      chk("mid reset readyOut", 32'(readyOut), 1);
      @(negedge clkIn);
      rstNIn = 1'b1;
      readyIn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clkIn);
         chk("flushed", 32'(validOut), 0);
      end

      // Random back-pressure stream of exact products (x1.0 or x2.0).
      issued = 0; got = 0; prevStall = 1'b0; prevData = '0; prevTag = '0;
      for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
         @(negedge clkIn);
         if (prevStall) begin
            chk("hold valid", 32'(validOut), 1);
            chk("hold data", dataOut, prevData);
            chk("hold tag", 32'(tagOut), 32'(prevTag));
         end
         readyIn = 1'($urandom_range(0, 1));
         if (issued < 10) begin
            a = (issued % 2 == 1) ? 32'h40000000 : 32'h3F800000;
            b = 32'h3FC00000 + 32'(issued) * 32'h00010000;
            dataAIn = a; dataBIn = b; rmIn = 3'd0; tagIn = 5'(10 + issued); validIn = 1'b1;
         end else begin
            validIn = 1'b0;
         end
         #1;
         chk("readyOut rule", 32'(readyOut), 32'(!(validOut && !readyIn)));
         if (validIn && readyOut) begin
            q.push_back({tagIn, (a == 32'h40000000) ? b + 32'h00800000 : b});
            issued++;
         end
         if (validOut && readyIn) begin
            if (q.size() == 0) begin
               chk("spurious result", 32'(q.size()), 1);
            end else begin
               e = q.pop_front();
               chk("stream tag", 32'(tagOut), 32'(e[36:32]));
               chk("stream data", dataOut, e[31:0]);
            end
            got++;
         end
         prevStall = validOut && !readyIn;
         prevData  = dataOut;
         prevTag   = tagOut;
      end
      validIn = 1'b0;
      readyIn = 1'b1;
      chk("stream count", 32'(got), 10);
      chk("stream drained", 32'(q.size()), 0);
      repeat (10) @(negedge clkIn);
      chk("no extra", 32'(validOut), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
